// File: rtl/fifo_read_controller_pkg.sv
// Shared defaults, FSM encoding and credit helper for the FIFO burst read controller.
// Pure declarations: no latency, no backpressure of its own.
package fifo_read_controller_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 5;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A new read may only issue if the words already committed to the buffer
    // (stored plus in flight, less the one leaving this cycle) leave a free slot.
    function automatic logic credit_ok(input logic [1:0] occupancy,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] committed;
        committed = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
        return committed < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_read_controller_if.sv
// Burst-control, FIFO-side and downstream-side signals of the read controller.
// Slave modport is the controller; master modport is whoever drives it.
interface fifo_read_controller_if
    import fifo_read_controller_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) ();

    logic              start;
    logic [LEN_W-1:0]  burst_len;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  words_left;

    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_data;

    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport slave (
        input  start, burst_len, fifo_empty, fifo_data, data_ready,
        output busy, done, words_left, fifo_rd_en, data_out, data_valid
    );

    modport master (
        output start, burst_len, fifo_empty, fifo_data, data_ready,
        input  busy, done, words_left, fifo_rd_en, data_out, data_valid
    );

endinterface

// File: rtl/fifo_read_skid.sv
// Two-entry in-order word buffer between the FIFO read port and the downstream consumer.
// Latency: a push is visible at head_data the next cycle; holds head stable until popped.
module fifo_read_skid
    import fifo_read_controller_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occupancy,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_data;
                    else               entry1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Replace the departing head, keeping any older second word ahead of the new one.
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occupancy = count;
    assign head_data = entry0;

    no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count == 2'd2) && !do_pop));

endmodule

// File: rtl/fifo_read_controller.sv
// Burst read controller: pulls burst_len words from a FIFO and presents them downstream.
// Latency: read at T gives data_valid at T+2 when empty; downstream stalls throttle reads via a 2-word credit.
module fifo_read_controller
    import fifo_read_controller_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                    clk,
    input  logic                    reset,
    fifo_read_controller_if.slave   bus
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  words_left;
    logic [LEN_W-1:0]  words_left_nxt;
    logic              inflight;
    logic              zero_done;
    logic              zero_start;
    logic [1:0]        occupancy;
    logic [DATA_W-1:0] head_data;
    logic              pop;
    logic              rd_en;
    logic              drain_done;

    assign pop        = (occupancy != 2'd0) && bus.data_ready;
    assign rd_en      = (state == ST_RUN) && !bus.fifo_empty && (words_left != '0)
                        && credit_ok(occupancy, inflight, pop);
    assign drain_done = (state == ST_DRAIN) && (occupancy == 2'd0) && !inflight;
    assign zero_start = (state == ST_IDLE) && bus.start && (bus.burst_len == '0);

    always_comb begin
        state_nxt      = state;
        words_left_nxt = words_left;
        case (state)
            ST_IDLE: begin
                if (bus.start && (bus.burst_len != '0)) begin
                    state_nxt      = ST_RUN;
                    words_left_nxt = bus.burst_len;
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    words_left_nxt = words_left - LEN_ONE;
                    if (words_left == LEN_ONE) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            words_left <= '0;
            inflight   <= 1'b0;
            zero_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            words_left <= words_left_nxt;
            inflight   <= rd_en;
            zero_done  <= zero_start;
        end
    end

    // The word requested last cycle is on fifo_data now; reset clears inflight, so a pending word is dropped.
    fifo_read_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (bus.fifo_data),
        .pop       (pop),
        .occupancy (occupancy),
        .head_data (head_data)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.data_valid = (occupancy != 2'd0);
    assign bus.data_out   = head_data;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = zero_done || drain_done;
    assign bus.words_left = words_left;

    idle_has_no_work: assert property (@(posedge clk) disable iff (!reset)
        (state != ST_RUN) |-> (words_left == '0));

endmodule

// File: doc/fifo_read_controller.md
FIFO_READ_CONTROLLER -- requirements
Module: fifo_read_controller

Interface
REQ-001 Parameter: DATA_W, 8, width of FIFO words and downstream data.
REQ-002 Parameter: LEN_W, 5, width of burst length and remaining-word count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle burst request; sampled only in IDLE.
REQ-006 burst_len  input  LEN_W  number of words to read, sampled with start (0..31).
REQ-007 busy  output  1  high while state is not IDLE.
REQ-008 done  output  1  one-cycle pulse when a burst has fully completed.
REQ-009 fifo_empty  input  1  FIFO has no readable word.
REQ-010 fifo_rd_en  output  1  FIFO read request, one word per asserted cycle.
REQ-011 fifo_data  input  DATA_W  FIFO read data, valid exactly one cycle after fifo_rd_en.
REQ-012 data_out  output  DATA_W  downstream word (processor 2 side).
REQ-013 data_valid  output  1  data_out holds a valid word.
REQ-014 data_ready  input  1  downstream accepts data_out when high with data_valid.
REQ-015 words_left  output  LEN_W  reads of the current burst not yet issued.

Function
REQ-016 FSM states shall be IDLE, RUN and DRAIN.
REQ-017 IDLE: start with burst_len != 0 shall load words_left = burst_len and go to RUN.
REQ-018 IDLE: start with burst_len == 0 shall pulse done the next cycle, issue no reads, and stay in IDLE.
REQ-019 start while busy shall be ignored, with no effect on words_left or state.
REQ-020 A 2-entry output buffer shall hold received words in order.
REQ-021 An in-flight flag shall mark a read issued on the previous cycle.
REQ-022 fifo_rd_en = RUN && !fifo_empty && words_left != 0 && (occupancy + inflight - pop) < 2, where pop = data_valid && data_ready.
REQ-023 Each asserted fifo_rd_en shall decrement words_left by 1.
REQ-024 When the last read issues (words_left 1 -> 0), the FSM shall go RUN -> DRAIN.
REQ-025 fifo_data shall be written into the buffer at the clock edge ending the cycle after fifo_rd_en.
REQ-026 Latency: fifo_rd_en in cycle T shall give data_valid with that word in cycle T+2 if the buffer was empty.
REQ-027 Sustained throughput shall be 1 word/cycle while the FIFO is non-empty and data_ready is high.
REQ-028 data_out and data_valid shall stay stable while data_valid && !data_ready.
REQ-029 Simultaneous buffer write and pop shall keep occupancy unchanged and preserve order.
REQ-030 The buffer shall never overflow, which the credit rule in REQ-022 guarantees.
REQ-031 fifo_empty high shall only stall reads and shall not raise an error or change state.
REQ-032 DRAIN -> IDLE with a one-cycle done pulse shall occur when occupancy == 0 and inflight == 0.
REQ-033 Exactly burst_len words shall be presented per burst, with no duplicates and no drops.

Reset
REQ-034 On reset low, asynchronously: state = IDLE, buffer occupancy = 0, inflight = 0, words_left = 0.
REQ-035 On reset low, asynchronously: fifo_rd_en = 0, data_valid = 0, done = 0, busy = 0, data_out = 0.
REQ-036 Reset asserted mid-burst shall abandon the burst; a word in flight shall be discarded, with no done pulse.
REQ-037 After reset deasserts, the first start shall be honoured on the first rising edge.

Structure
REQ-038 A shared package/header shall hold the FSM state encodings plus DATA_W and LEN_W defaults.
REQ-039 The 2-entry buffer shall be one sub-module, fifo_read_skid, with push, pop, occupancy and head data.
REQ-040 The FSM and credit logic shall live in fifo_read_controller.

Verification
REQ-041 Basic burst: FIFO holds 0x11,0x22,0x33; burst_len=3; data_ready=1.
 - fifo_rd_en for 3 consecutive cycles.
 - data_out 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first read.
 - done 1 cycle after the last word is accepted.
REQ-042 Backpressure: burst_len=4, data_ready=0 for 6 cycles.
 - Exactly 2 reads issue, then fifo_rd_en stays low.
 - data_out stays stable.
 - On release, all 4 words arrive in order.
REQ-043 Empty stall: burst_len=2, fifo_empty=1 for 5 cycles, then 2 words.
 - No fifo_rd_en while empty; busy=1 throughout.
 - Completes with done after the words arrive.
REQ-044 Zero length / ignored start: start with burst_len=0 gives done next cycle and no fifo_rd_en; start pulses during a busy burst of 5 give exactly 5 words.
REQ-045 Reset mid-burst: reset low after 2 of 8 words.
 - All outputs 0 immediately.
 - A new burst_len=1 then reads exactly 1 word.
